// File: rtl/modem_defn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : modem_defn_pkg
//  Purpose  : Shared modem receive-path types and constants (ADC capture FSM
//             states, capture FIFO entry layout, default ADC/packet sizes).
//  Revision : 1.0  initial release
// ============================================================================
package modem_defn_pkg;

    localparam int CAP_ADC_WIDTH = 14;
    localparam int CAP_PKT_LEN   = 500;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } adc_cap_state_e;

    typedef struct packed {
        logic                     sop;
        logic                     eop;
        logic [CAP_ADC_WIDTH-1:0] data;
    } adc_cap_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with first-word-fall-through read data.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_sample_capture.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sample_capture
//  Purpose  : Frames ADC samples into fixed-length SOP/EOP packets, buffers
//             them in a FIFO and streams them out on valid/ready.
//             Define ADC_CAP_PEAK_EN to add the per-packet |sample| peak output.
//  Revision : 1.0  initial release
// ============================================================================
module adc_sample_capture
    import modem_defn_pkg::*;
#(
    parameter int ADC_WIDTH     = CAP_ADC_WIDTH,
    parameter int PKT_LEN       = CAP_PKT_LEN,
    parameter int FIFO_DEPTH    = 16,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic [ADC_WIDTH-1:0]     adc_data_i,
    input  logic                     adc_valid_i,
    output logic [ADC_WIDTH-1:0]     m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     m_sop_o,
    output logic                     m_eop_o,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count_o,
    output logic                     overflow_o,
    input  logic                     clr_ovf_i,
    output logic                     busy_o
`ifdef ADC_CAP_PEAK_EN
    ,
    output logic [ADC_WIDTH-1:0]     peak_o
`endif
);

    localparam int IDX_W = $clog2(PKT_LEN);

    typedef struct packed {
        logic                 sop;
        logic                 eop;
        logic [ADC_WIDTH-1:0] data;
    } entry_t;

    adc_cap_state_e     r_state;
    logic [IDX_W-1:0]   r_idx;
    entry_t             r_stage;
    logic               r_stage_vld;

    logic               w_accept;
    logic               w_last;
    logic               w_pop;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [ADC_WIDTH+1:0] w_rd_raw;
    entry_t             w_rd;

    assign w_last = (r_idx == IDX_W'(PKT_LEN - 1));

    // Once a packet has started, en_i is ignored until its EOP sample.
    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            IDLE:    w_accept = en_i && adc_valid_i;
            CAPTURE: w_accept = adc_valid_i && (en_i || (r_idx != '0));
            default: w_accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_stage     <= '0;
            r_stage_vld <= 1'b0;
        end else begin
            r_stage_vld <= w_accept;
            if (w_accept) begin
                r_stage.sop  <= (r_idx == '0);
                r_stage.eop  <= w_last;
                r_stage.data <= adc_data_i;
                r_idx        <= w_last ? '0 : r_idx + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!en_i && ((r_idx == '0) || (w_accept && w_last))) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_empty && !r_stage_vld) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (ADC_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_stage_vld),
        .wdata (r_stage),
        .pop   (w_pop),
        .rdata (w_rd_raw),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_rd      = w_rd_raw;
    assign w_pop     = m_valid_o && m_ready_i;
    assign w_drop    = r_stage_vld && w_full && !w_pop;

    // Gate the unreset FIFO storage so outputs read zero while empty.
    assign m_valid_o = !w_empty;
    assign m_data_o  = w_empty ? '0 : w_rd.data;
    assign m_sop_o   = !w_empty && w_rd.sop;
    assign m_eop_o   = !w_empty && w_rd.eop;
    assign busy_o    = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_o  <= 1'b0;
            pkt_count_o <= '0;
        end else begin
            if (w_drop) begin
                overflow_o <= 1'b1;
            end else if (clr_ovf_i) begin
                overflow_o <= 1'b0;
            end
            if (w_pop && w_rd.eop) begin
                pkt_count_o <= pkt_count_o + 1'b1;
            end
        end
    end

`ifdef ADC_CAP_PEAK_EN
    logic [ADC_WIDTH-1:0] r_run_max;
    logic                 r_peak_load;
    logic [ADC_WIDTH-1:0] w_abs;

    // Magnitude of the most negative code is 2^(ADC_WIDTH-1), still in range unsigned.
    assign w_abs = adc_data_i[ADC_WIDTH-1] ? (~adc_data_i + 1'b1) : adc_data_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run_max   <= '0;
            r_peak_load <= 1'b0;
            peak_o      <= '0;
        end else begin
            r_peak_load <= w_accept && w_last;
            if (w_accept) begin
                r_run_max <= ((r_idx == '0) || (w_abs > r_run_max)) ? w_abs : r_run_max;
            end
            if (r_peak_load) begin
                peak_o <= r_run_max;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/adc_sample_capture.md
Name: adc_sample_capture

Overview:
- DUT-side receiving end of the ADC sample interface that the ADC agent drives.
- Accepts one signed 14-bit ADC sample per valid cycle, frames the samples into fixed-length packets, and buffers them in a small FIFO.
- Presents the packets on a valid/ready stream with start-of-packet and end-of-packet markers.
- Sits at the front of the modem receive path, ahead of the demodulator.

Parameters:
- ADC_WIDTH, 14, sample width in bits (signed two's complement).
- PKT_LEN, 500, samples per packet (>=2).
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2.
- PKT_CNT_WIDTH, 16, width of the packet counter.

Ports:
- clk  in  1  sample clock.
- rst_n  in  1  reset; synchronous, active-low.
- en_i  in  1  capture enable.
- adc_data_i  in  ADC_WIDTH  ADC sample.
- adc_valid_i  in  1  sample strobe.
- m_data_o  out  ADC_WIDTH  output sample.
- m_valid_o  out  1  output valid.
- m_ready_i  in  1  downstream ready.
- m_sop_o  out  1  first sample of a packet.
- m_eop_o  out  1  last sample of a packet.
- pkt_count_o  out  PKT_CNT_WIDTH  packets delivered downstream.
- overflow_o  out  1  sticky flag: a sample was dropped.
- clr_ovf_i  in  1  clears overflow_o.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0.
  - FIFO is flushed; sample index goes to 0; FSM goes to IDLE.
  - A reset mid-packet discards the partial packet; the next packet starts with SOP.
- FSM states:
  - IDLE: go to CAPTURE on en_i=1 && adc_valid_i=1. That sample is accepted as index 0.
  - CAPTURE: every adc_valid_i=1 cycle is accepted and the index increments.
    - At index PKT_LEN-1: the sample is tagged EOP and the index wraps to 0.
    - After an EOP: stay in CAPTURE if en_i=1, else go to DRAIN.
    - en_i dropping mid-packet has no effect until that packet's EOP sample has been accepted; packets are never truncated.
  - DRAIN: accept no input. Go to IDLE when the FIFO is empty.
- FIFO entry is {sop, eop, data}, ADC_WIDTH+2 bits. sop is set when index==0.
- Output side:
  - Reads are first-word-fall-through; m_valid_o = !empty.
  - A beat transfers when m_valid_o && m_ready_i.
  - m_data_o, m_sop_o and m_eop_o stay stable while m_valid_o && !m_ready_i.
- Latency: a sample accepted on edge N is visible on m_data_o after edge N+1.
- Overflow and full handling:
  - A write while full with no pop in the same cycle: the sample is dropped and overflow_o is set.
  - The index still advances on a dropped sample, so packet framing stays aligned to ADC time.
  - Full with a simultaneous pop: the write is accepted and no overflow is flagged.
  - clr_ovf_i=1 clears overflow_o. If an overflow occurs in the same cycle, set wins.
- Empty handling: m_ready_i with an empty FIFO is ignored.
- pkt_count_o increments on each transferred EOP beat. It wraps modulo 2^PKT_CNT_WIDTH.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: ADC_CAP_PEAK_EN.
- With the macro defined:
  - Adds output port peak_o, ADC_WIDTH bits, unsigned.
  - Per packet, a running maximum of |sample| is tracked over accepted samples, including dropped ones.
  - |−2^(ADC_WIDTH−1)| = 2^(ADC_WIDTH−1) and fits in ADC_WIDTH bits.
  - peak_o is updated on the edge after the EOP sample is accepted, then holds.
  - The running maximum restarts at the next SOP.
  - Reset value is 0.
- Without the macro: no peak_o port and no peak logic.

Decomposition:
- Shared modem_defn_pkg gains:
  - The ADC_WIDTH and packet-length constants.
  - adc_cap_state_e enum {IDLE, CAPTURE, DRAIN}.
  - An adc_cap_entry_t packed struct {sop, eop, data}.
- Sub-module sync_fifo (parameters WIDTH and DEPTH):
  - Ports: push, pop, full, empty.
  - Read data is first-word-fall-through.
  - Synchronous active-low reset.

Test Plan:
1. Reset behaviour: hold rst_n=0 for 50 cycles with adc_valid_i=1 and random data. Required: all outputs 0, m_valid_o=0.
2. Single packet: en_i=1, 500 continuous samples 0..499, m_ready_i=1. Required: 500 beats in order; first beat one cycle after the first acceptance with m_sop_o=1 and data 0; m_eop_o only on data 499; pkt_count_o=1; busy_o falls after the drain.
3. Ten tone packets with backpressure: adc_valid_i every other cycle, m_ready_i toggling 50%. Required: 5000 beats matching the scoreboard, overflow_o=0, pkt_count_o=10.
4. Overflow: m_ready_i=0, 20 samples, FIFO_DEPTH=16. Required: 16 entries held; overflow_o=1 after the 17th sample edge; clr_ovf_i pulse clears it.
5. Enable dropped mid-packet: en_i falls after 100 samples. Required: capture continues to 500 samples with EOP, then DRAIN, then IDLE; a later en_i starts a fresh packet with SOP.
6. Reset mid-packet: rst_n low for 1 cycle at sample 250, then resume. Required: FIFO empty, pkt_count_o=0, and the next sample emerges with m_sop_o=1.
   - With ADC_CAP_PEAK_EN defined: a packet containing −8192 and +8191 gives peak_o=8192 after EOP.
